// File: rtl/tinyrisc_pkg.sv
// Shared TinyRISC definitions: datapath widths, the NOP encoding and the
// fetch controller state encoding.
package tinyrisc_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [31:0] NOP = 32'h6800_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks an instruction acknowledged while the
// IF/OF register is stalled, until OF can accept it.
module fetch_hold_buf
  import tinyrisc_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // Buffer entry: flush and clear both empty it, load captures a new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP);
      valid_q <= 1'b0;
    end else if (flush_i || clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// TinyRISC fetch-stage controller: owns the PC, runs the instruction-memory
// req/ack handshake and drives the IF/OF register with stall, redirect and halt.
module fetch_ctrl
  import tinyrisc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    addr_q;
  logic               req_q;
  logic [PC_W-1:0]    if_pc_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic               if_valid_q;
  logic               halted_q;
  logic               drop_q;
  logic               halt_pend_q;

  logic               hb_load_s;
  logic               hb_clear_s;
  logic               hb_flush_s;
  logic [PC_W-1:0]    hb_pc_s;
  logic [INSTR_W-1:0] hb_instr_s;
  logic               hb_valid_s;
  logic [PC_W-1:0]    pc_inc_s;

  assign pc_inc_s = pc_q + PC_ONE;

  // Hold-buffer controls, decoded from the same priorities the FSM applies.
  always_comb begin
    hb_load_s  = 1'b0;
    hb_clear_s = 1'b0;
    hb_flush_s = 1'b0;
    case (state_q)
      ST_FETCH: hb_load_s = imem_ack && stall && !branch_taken && !halt
                            && !halt_pend_q && !drop_q;
      ST_HOLD: begin
        hb_flush_s = branch_taken || halt;
        hb_clear_s = !branch_taken && !halt && !stall;
      end
      default: hb_load_s = 1'b0;
    endcase
  end

  fetch_hold_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (hb_load_s),
    .clear_i (hb_clear_s),
    .flush_i (hb_flush_s),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .pc_o    (hb_pc_s),
    .instr_o (hb_instr_s),
    .valid_o (hb_valid_s)
  );

  // Fetch FSM. addr_q tracks pc_q except while a redirected request is still
  // waiting for its ack, when it keeps presenting the abandoned address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= INSTR_W'(NOP);
      if_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      drop_q      <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (branch_taken) begin
            pc_q    <= branch_target;
            addr_q  <= branch_target;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end else if (halt) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (branch_taken) begin
            if_valid_q  <= 1'b0;
            pc_q        <= branch_target;
            halt_pend_q <= 1'b0;
            if (imem_ack) begin
              addr_q <= branch_target;
              drop_q <= 1'b0;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (halt || halt_pend_q) begin
            if_valid_q <= 1'b0;
            if (imem_ack) begin
              state_q     <= ST_HALT;
              req_q       <= 1'b0;
              halted_q    <= 1'b1;
              halt_pend_q <= 1'b0;
              drop_q      <= 1'b0;
            end else begin
              halt_pend_q <= 1'b1;
            end
          end else if (drop_q) begin
            if (!stall) if_valid_q <= 1'b0;
            if (imem_ack) begin
              drop_q <= 1'b0;
              addr_q <= pc_q;
            end
          end else if (imem_ack) begin
            pc_q   <= pc_inc_s;
            addr_q <= pc_inc_s;
            if (stall) begin
              state_q <= ST_HOLD;
              req_q   <= 1'b0;
            end else begin
              if_pc_q    <= pc_q;
              if_instr_q <= imem_rdata;
              if_valid_q <= 1'b1;
            end
          end else if (!stall) begin
            if_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (branch_taken) begin
            if_valid_q <= 1'b0;
            pc_q       <= branch_target;
            addr_q     <= branch_target;
            state_q    <= ST_FETCH;
            req_q      <= 1'b1;
          end else if (halt) begin
            if_valid_q <= 1'b0;
            state_q    <= ST_HALT;
            halted_q   <= 1'b1;
          end else if (!stall) begin
            if_pc_q    <= hb_pc_s;
            if_instr_q <= hb_instr_s;
            if_valid_q <= hb_valid_s;
            state_q    <= ST_FETCH;
            req_q      <= 1'b1;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// wrap/async-reset sequence and a randomized program-order stream check.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_valid      (if_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic        halt;
    logic        ack;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_halted;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic h, input logic a);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    halt          = h;
    imem_ack      = a;
    imem_rdata    = mem_word(imem_addr);
  endtask

  task automatic check_reset(input string nm);
    chk(nm, {imem_req, imem_addr, if_pc, if_instr, if_valid, halted},
        {1'b0, 32'h0, 32'h0, 32'h6800_0000, 1'b0, 1'b0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_reset("reset_values");
    rst = 1'b1;
  endtask

  // randomized run state
  logic        p_valid, p_stall, p_branch, p_req, p_ack;
  logic [31:0] p_pc, p_instr, p_target, p_addr;
  logic [31:0] exp_pc;
  logic        mem_pend;
  int          mem_cnt;
  int          consumed;
  logic        r_stall, r_br, r_ack;
  logic [31:0] r_tgt;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // stall, br, halt, ack, tgt | req, addr, valid, if_pc, halted
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h1,  1'b1, 32'h0,  1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h2,  1'b1, 32'h1,  1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h3,  1'b1, 32'h1,  1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h3,  1'b1, 32'h1,  1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h3,  1'b1, 32'h2,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h3,  1'b0, 32'h2,  1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h3,  1'b0, 32'h2,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h40, 1'b0, 32'h2,  1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h41, 1'b1, 32'h40, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h40, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h20, 1'b0, 32'h40, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h20, 1'b0, 32'h40, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h20, 1'b0, 32'h40, 1'b1};

    // Directed vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("row%0d", i),
          {imem_req, imem_addr, if_valid, if_pc, halted},
          {tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_valid, tbl[i].exp_pc, tbl[i].exp_halted});
      if (tbl[i].exp_valid) chk($sformatf("row%0d_instr", i), if_instr, mem_word(tbl[i].exp_pc));
      drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].halt, tbl[i].ack);
      @(negedge clk);
    end

    // PC wrap, then asynchronous reset in the middle of a stall
    do_reset();
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_req", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFF});
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap_addr", {imem_addr, if_pc, if_valid}, {32'h0, 32'hFFFF_FFFF, 1'b1});
    chk("wrap_instr", if_instr, mem_word(32'hFFFF_FFFF));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_hold", {imem_req, imem_addr, if_pc, if_valid}, {1'b0, 32'h1, 32'hFFFF_FFFF, 1'b1});
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_reset("async_reset");

    // Randomized stream check against a program-order model
    do_reset();
    exp_pc   = 32'h0;
    mem_pend = 1'b0;
    mem_cnt  = 0;
    consumed = 0;
    p_valid = if_valid; p_pc = if_pc; p_instr = if_instr;
    p_stall = 1'b0; p_branch = 1'b0; p_target = 32'h0;
    p_req = imem_req; p_ack = 1'b0; p_addr = imem_addr;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (p_branch) begin
        chk("branch_bubble", if_valid, 1'b0);
        exp_pc = p_target;
      end else begin
        if (!p_stall && p_valid) begin
          chk("stream_pc", p_pc, exp_pc);
          chk("stream_instr", p_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd1;
          consumed++;
        end
        if (p_stall) chk("rand_stall_hold", {if_valid, if_pc, if_instr}, {p_valid, p_pc, p_instr});
      end
      if (p_req && !p_ack) chk("req_stable", {imem_req, imem_addr}, {1'b1, p_addr});

      r_stall = ($urandom_range(0, 3) == 0);
      r_br    = ($urandom_range(0, 9) == 0);
      r_tgt   = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFFE + 32'($urandom_range(0, 1)));
      if (imem_req) begin
        if (!mem_pend) begin
          mem_pend = 1'b1;
          mem_cnt  = $urandom_range(0, 2);
        end
        if (mem_cnt == 0) begin
          r_ack    = 1'b1;
          mem_pend = 1'b0;
        end else begin
          r_ack = 1'b0;
          mem_cnt--;
        end
      end else begin
        r_ack    = 1'b0;
        mem_pend = 1'b0;
      end
      drive(r_stall, r_br, r_tgt, 1'b0, r_ack);

      p_valid = if_valid; p_pc = if_pc; p_instr = if_instr;
      p_stall = r_stall; p_branch = r_br; p_target = r_tgt;
      p_req = imem_req; p_ack = r_ack; p_addr = imem_addr;
    end
    n_chk++;
    if (consumed < 200) begin
      n_fail++;
      $display("FAIL progress: got %0d instructions consumed, expected at least 200", consumed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the TinyRISC pipeline. It owns the program counter and sequences the instruction-memory port with a req/ack handshake. It drives the IF/OF pipeline register contents, applying branch redirects from EX, load-use stalls from OF and halt. It replaces the free-running PC increment so that the fetch stage supports multi-cycle instruction memory, stalls, flushes and halt.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_W, 32, PC and memory address width
- INSTR_W, 32, instruction width

- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  PC_W  word address of the request; equals current PC
- imem_ack  in  1  memory has valid imem_rdata this cycle (may be same cycle as req)
- imem_rdata  in  INSTR_W  fetched instruction, valid when imem_ack
- stall  in  1  OF hazard: hold IF/OF contents unchanged
- branch_taken  in  1  EX redirect; highest priority
- branch_target  in  PC_W  redirect address
- halt  in  1  OF has decoded a valid halt instruction
- if_pc  out  PC_W  IF/OF register: PC of if_instr
- if_instr  out  INSTR_W  IF/OF register: instruction
- if_valid  out  1  IF/OF register holds a real instruction (0 = bubble)
- halted  out  1  controller is in HALT

## Operation
- States: IDLE, FETCH, HOLD, HALT. Reset enters IDLE. IDLE moves to FETCH unconditionally on the next edge.
- Reset values: pc=RESET_PC, imem_req=0, if_pc=0, if_instr=NOP, if_valid=0, halted=0, hold buffer empty, drop flag 0.
- Memory protocol:
  - imem_req=1 only in FETCH.
  - While a request is unacknowledged, imem_addr and imem_req stay stable, including across branch and stall.
  - One outstanding request maximum.
- FETCH, ack, no stall, no branch: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+1.
- FETCH, ack, stall: IF/OF unchanged. rdata and pc go into the hold buffer, pc<=pc+1, state goes to HOLD, req drops.
- FETCH, no ack, no stall: if_valid<=0 (bubble), pc unchanged.
- HOLD while stall: all unchanged, imem_req=0.
- HOLD when stall deasserts: load the hold buffer into IF/OF with if_valid=1, then go to FETCH.
- Any stall cycle: IF/OF registers hold their values; if_valid is not cleared.
- branch_taken (any non-HALT state, overrides stall and halt):
  - if_valid<=0, hold buffer discarded, pc<=branch_target, next state FETCH.
  - If a request is outstanding without ack this cycle, set drop flag. The request stays up at the old address until ack, that response is discarded, then fetching resumes at the target.
- Ack with drop flag set: response discarded, if_valid<=0, drop flag cleared, next request uses current pc.
- halt without branch_taken: go to HALT after an outstanding request completes, with its response discarded. if_valid<=0, imem_req=0, halted=1. Only reset leaves HALT; branch_taken is ignored in HALT.
- PC arithmetic: word addressed, +1 per instruction, wraps modulo 2^PC_W (32'hFFFF_FFFF goes to 0).

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. The instruction at PC p is on if_* the cycle after the edge on which p was acknowledged.
- First request is asserted the second cycle after rst deasserts (IDLE, then FETCH).
- Branch penalty with zero-wait memory: the target instruction appears on if_* 2 edges after the branch_taken edge (1 bubble on if_valid).
- If stall and branch_taken are asserted together, the branch wins.
- rst assertion mid-request drops imem_req asynchronously. Memory must tolerate abandoned requests.

## Structure
- Shared package tinyrisc_pkg: NOP constant (32'h6800_0000), fetch state enum, PC_W/INSTR_W defaults.
- One sub-module is natural: fetch_hold_buf, a single-entry buffer holding {pc, instr, valid} with load, clear and flush controls.

## Test plan
- Reset release with ack tied 1: imem_addr sequence 0,1,2,3; if_pc follows one cycle later; if_valid=1 from the third edge.
- Ack delayed 2 cycles per request: imem_addr is stable while waiting, 2 bubbles appear between instructions, and pc advances only on ack.
- Stall for 3 cycles at the same time as an ack of addr 5: IF/OF keeps instr 4. Instr 5 appears the cycle stall drops, then fetch resumes at 6 with no duplicate and no loss.
- branch_taken to 0x40 while a request for addr 9 is pending (ack 2 cycles later): the response for 9 is discarded, next imem_addr=0x40, and if_valid=0 until instr 0x40.
- halt at PC 7 and branch_taken asserted together: the branch wins. A later halt alone sets halted=1 and imem_req=0, and the state holds until rst.
- PC at 32'hFFFF_FFFF: next imem_addr=0. Asserting rst mid-stall returns all outputs to their reset values immediately.
